// File: rtl/uart_pkg.sv
// Shared parity codes, FSM state constants and the parity helper for the
// parametrised UART transceiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PAR     = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  // Word is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    logic par;
    par = 1'b0;
    case (mode)
      PAR_ODD:  par = ~^word;
      PAR_EVEN: par = ^word;
      default:  par = 1'b0;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: two-flop rx synchroniser, mid-bit sampling FSM with false-start
// rejection, and per-word parity/framing error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_ODD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              read_rdy,
  output logic [DATA_W-1:0] read_data,
  output logic              read_par_err,
  output logic              read_frm_err
);

  localparam int T_W = $clog2(CLKS_PER_BIT);
  localparam int B_W = $clog2(DATA_W);

  localparam logic [T_W-1:0] T_HALF = T_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [T_W-1:0] T_FULL = T_W'(CLKS_PER_BIT - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_W - 1);

  logic              rx_s1;
  logic              rx_s2;
  logic              rx_d;
  state_t            state;
  logic [T_W-1:0]    timer;
  logic [B_W-1:0]    bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_err;
  logic              tick;

  assign tick = (timer == T_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_d         <= 1'b1;
      state        <= ST_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_err      <= 1'b0;
      read_rdy     <= 1'b0;
      read_data    <= '0;
      read_par_err <= 1'b0;
      read_frm_err <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      read_rdy <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_d && !rx_s2) begin
            state <= ST_START;
            timer <= '0;
          end
        end

        // Re-check half a bit in; a line that is high again was only a glitch.
        ST_START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_cnt <= '0;
            par_err <= 1'b0;
            state   <= rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick) begin
            timer <= '0;
            shift <= {rx_s2, shift[DATA_W-1:1]};
            if (bit_cnt == B_LAST) begin
              state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_PAR: begin
          if (tick) begin
            timer   <= '0;
            par_err <= rx_s2 ^ parity_bit(9'(shift), PARITY);
            state   <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Only the first stop bit is checked; a low stop waits out a break.
        ST_STOP: begin
          if (tick) begin
            timer        <= '0;
            read_rdy     <= 1'b1;
            read_data    <= shift;
            read_par_err <= par_err;
            read_frm_err <= !rx_s2;
            state        <= rx_s2 ? ST_IDLE : ST_WAIT_HI;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_WAIT_HI: begin
          if (rx_s2) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: serialises an NWORDS-word command onto tx
// (high word first) and hands received words to the host via uart_rx_core.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NWORDS       = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_ODD,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWORDS*DATA_W-1:0] cmd_in,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  output logic                     tx,
  input  logic                     rx,
  output logic                     read_rdy,
  output logic [DATA_W-1:0]        read_data,
  output logic                     read_par_err,
  output logic                     read_frm_err
);

  localparam int CMD_W = NWORDS * DATA_W;
  localparam int T_W   = $clog2(CLKS_PER_BIT);
  localparam int B_W   = $clog2(DATA_W);
  localparam int W_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [T_W-1:0] T_FULL    = T_W'(CLKS_PER_BIT - 1);
  localparam logic [B_W-1:0] B_LAST    = B_W'(DATA_W - 1);
  localparam logic [W_W-1:0] W_LAST    = W_W'(NWORDS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  state_t            tx_state;
  logic [T_W-1:0]    tx_timer;
  logic [B_W-1:0]    tx_bit_cnt;
  logic [W_W-1:0]    word_cnt;
  logic              stop_cnt;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par;
  logic              tx_tick;
  logic [DATA_W-1:0] load_word;
  logic              load_par;

  assign cmd_rdy = (tx_state == ST_IDLE);
  assign tx_tick = (tx_timer == T_FULL);

  // The next word comes straight from cmd_in on accept, else from the latched remainder.
  assign load_word = (tx_state == ST_IDLE) ? cmd_in[CMD_W-1 -: DATA_W]
                                           : cmd_q[CMD_W-1 -: DATA_W];
  assign load_par  = parity_bit(9'(load_word), PARITY);

  // NOTE: every state update below uses <= so each flop samples pre-edge values,
  // and rst_n is synchronous: it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= ST_IDLE;
      tx         <= 1'b1;
      tx_timer   <= '0;
      tx_bit_cnt <= '0;
      word_cnt   <= '0;
      stop_cnt   <= 1'b0;
      cmd_q      <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (cmd_vld) begin
            tx_state <= ST_START;
            tx       <= 1'b0;
            tx_timer <= '0;
            word_cnt <= '0;
            tx_shift <= load_word;
            tx_par   <= load_par;
            cmd_q    <= cmd_in << DATA_W;
          end
        end

        ST_START, ST_DATA, ST_PAR, ST_STOP: begin
          if (!tx_tick) begin
            tx_timer <= tx_timer + 1'b1;
          end else begin
            tx_timer <= '0;
            case (tx_state)
              ST_START: begin
                tx_state   <= ST_DATA;
                tx         <= tx_shift[0];
                tx_shift   <= tx_shift >> 1;
                tx_bit_cnt <= '0;
              end

              ST_DATA: begin
                if (tx_bit_cnt == B_LAST) begin
                  stop_cnt <= 1'b0;
                  if (PARITY == PAR_NONE) begin
                    tx_state <= ST_STOP;
                    tx       <= 1'b1;
                  end else begin
                    tx_state <= ST_PAR;
                    tx       <= tx_par;
                  end
                end else begin
                  tx_bit_cnt <= tx_bit_cnt + 1'b1;
                  tx         <= tx_shift[0];
                  tx_shift   <= tx_shift >> 1;
                end
              end

              ST_PAR: begin
                tx_state <= ST_STOP;
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end

              // Stop bit finished: either the next word starts with no gap or the command ends.
              default: begin
                if (stop_cnt != STOP_LAST) begin
                  stop_cnt <= 1'b1;
                end else if (word_cnt != W_LAST) begin
                  word_cnt <= word_cnt + 1'b1;
                  tx_state <= ST_START;
                  tx       <= 1'b0;
                  tx_shift <= load_word;
                  tx_par   <= load_par;
                  cmd_q    <= cmd_q << DATA_W;
                end else begin
                  tx_state <= ST_IDLE;
                  tx       <= 1'b1;
                end
              end
            endcase
          end
        end

        default: begin
          tx_state <= ST_IDLE;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  uart_rx_core #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .read_rdy     (read_rdy),
    .read_data    (read_data),
    .read_par_err (read_par_err),
    .read_frm_err (read_frm_err)
  );

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Self-checking bench for uart_xcvr_param (8-bit words, 2 words, 4 clk/bit,
// odd parity, 1 stop bit) against a bit-list model and a received-word queue.
module tb_uart_xcvr_param;
  import uart_pkg::*;

  localparam int DATA_W    = 8;
  localparam int NWORDS    = 2;
  localparam int CPB       = 4;
  localparam int STOP_BITS = 1;
  localparam int FRAME     = 1 + DATA_W + 1 + STOP_BITS;
  localparam int BUSY      = NWORDS * FRAME * CPB;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] cmd_in  = '0;
  logic        cmd_vld = 1'b0;
  logic        rx_drv  = 1'b1;
  logic        loop    = 1'b0;
  logic        cmd_rdy;
  logic        tx;
  logic        read_rdy;
  logic [7:0]  read_data;
  logic        read_par_err;
  logic        read_frm_err;
  wire         rx_line = loop ? tx : rx_drv;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } rx_rec_t;

  rx_rec_t rxq[$];

  uart_xcvr_param #(
    .DATA_W       (DATA_W),
    .NWORDS       (NWORDS),
    .CLKS_PER_BIT (CPB),
    .PARITY       (PAR_ODD),
    .STOP_BITS    (STOP_BITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_in       (cmd_in),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .tx           (tx),
    .rx           (rx_line),
    .read_rdy     (read_rdy),
    .read_data    (read_data),
    .read_par_err (read_par_err),
    .read_frm_err (read_frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read_rdy) rxq.push_back(rx_rec_t'({read_data, read_par_err, read_frm_err}));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic expect_rx(input logic [7:0] d, input logic p, input logic f);
    rx_rec_t r;
    check("rx_avail", 32'(rxq.size() != 0), 1);
    if (rxq.size() != 0) begin
      r = rxq.pop_front();
      check("rx_data", r.d, d);
      check("rx_par_err", r.p, p);
      check("rx_frm_err", r.f, f);
    end
  endtask

  // Called at a negedge while cmd_rdy is expected high; acceptance is at the next posedge.
  task automatic start_cmd(input logic [15:0] c);
    check("rdy_before_accept", cmd_rdy, 1);
    cmd_in  = c;
    cmd_vld = 1'b1;
  endtask

  // Walks the busy period cycle by cycle, comparing tx to the expected bit list.
  task automatic check_stream(input logic [15:0] c, input bit release_vld, input logic [15:0] next_in);
    logic exp_bits[$];
    int   n;
    for (int w = 0; w < NWORDS; w++) begin
      logic [7:0] word;
      word = c[15 - 8*w -: 8];
      exp_bits.push_back(1'b0);
      for (int b = 0; b < DATA_W; b++) exp_bits.push_back(word[b]);
      exp_bits.push_back(odd_par(word));
      exp_bits.push_back(1'b1);
    end
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (n == 0) begin
        cmd_in = next_in;
        if (release_vld) cmd_vld = 1'b0;
      end
      if (cmd_rdy) break;
      if (n < BUSY) check("tx_bit", tx, exp_bits[n / CPB]);
      n++;
    end
    check("busy_cycles", n, BUSY);
    check("tx_idle_after", tx, 1);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic p, input logic s, input int stop_len);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat ((i == 10) ? stop_len : CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] c2;
    logic [7:0]  d;
    logic        p;
    logic        s;

    // Reset held three clocks
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_read_rdy", read_rdy, 0);
    check("rst_read_data", read_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed command on tx, looped back into rx
    loop = 1'b1;
    start_cmd(16'hA55A);
    check_stream(16'hA55A, 1'b1, 16'($urandom));
    repeat (8) @(negedge clk);
    expect_rx(8'hA5, 1'b0, 1'b0);
    expect_rx(8'h5A, 1'b0, 1'b0);

    // Random loopback commands
    for (int k = 0; k < 4; k++) begin
      c = 16'($urandom);
      start_cmd(c);
      check_stream(c, 1'b1, 16'($urandom));
      repeat (8) @(negedge clk);
      expect_rx(c[15:8], 1'b0, 1'b0);
      expect_rx(c[7:0], 1'b0, 1'b0);
    end
    loop = 1'b0;
    repeat (4) @(negedge clk);

    // Wrong parity bit
    drive_rx(8'h3C, 1'b0, 1'b1, CPB);
    expect_rx(8'h3C, 1'b1, 1'b0);

    // Low stop bit followed by a long break, then a clean frame
    drive_rx(8'h55, 1'b1, 1'b0, CPB + 20);
    check("frm_single_pulse", rxq.size(), 1);
    expect_rx(8'h55, 1'b0, 1'b1);
    drive_rx(8'h81, 1'b1, 1'b1, CPB);
    expect_rx(8'h81, 1'b0, 1'b0);

    // One-clock glitch is rejected as a false start
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("false_start_no_rdy", rxq.size(), 0);

    // Random rx frames with random parity and stop bits
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = 1'($urandom);
      drive_rx(d, p, s, CPB);
      expect_rx(d, p ^ odd_par(d), !s);
    end

    // cmd_vld held through busy with a new cmd_in: second command waits for cmd_rdy
    loop = 1'b1;
    c  = 16'($urandom);
    c2 = 16'($urandom);
    start_cmd(c);
    check_stream(c, 1'b0, c2);
    check_stream(c2, 1'b1, 16'($urandom));
    repeat (8) @(negedge clk);
    expect_rx(c[15:8], 1'b0, 1'b0);
    expect_rx(c[7:0], 1'b0, 1'b0);
    expect_rx(c2[15:8], 1'b0, 1'b0);
    expect_rx(c2[7:0], 1'b0, 1'b0);
    loop = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the first word
    start_cmd(16'h1234);
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_tx_busy", cmd_rdy, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_cmd_rdy", cmd_rdy, 1);
    check("mid_rst_read_rdy", read_rdy, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_tx_idle", tx, 1);
    check("rx_queue_empty", rxq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
